// File: rtl/imem_axi_ctrl.sv
// Dual-region (main / ISP) instruction memory with a read-only fetch port and an
// AXI4-Lite slave port that shares the arrays through a round-robin read/write arbiter.
module imem_axi_ctrl #(
  parameter int          MAIN_DEPTH = 4096,
  parameter int          ISP_DEPTH  = 1024,
  parameter logic [31:0] RST_PC     = 32'h0800_0000,
  parameter int          REGION_BIT = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_n_i,
  input  logic        fetch_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        fetch_err_o,
  output logic        busy_o,
  input  logic        isp_lock_i,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awprot,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready
);

  localparam int          MAIN_AW = (MAIN_DEPTH > 1) ? $clog2(MAIN_DEPTH) : 1;
  localparam int          ISP_AW  = (ISP_DEPTH > 1) ? $clog2(ISP_DEPTH) : 1;
  localparam logic [29:0] MAIN_LIM = 30'(MAIN_DEPTH);
  localparam logic [29:0] ISP_LIM  = 30'(ISP_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_BOOT, S_LOAD, S_RUN} boot_state_e;

  // The region-select bit is not part of the word index inside a region.
  function automatic logic [29:0] word_idx(input logic [29:0] w);
    logic [29:0] m;
    m = w;
    m[REGION_BIT-2] = 1'b0;
    return m;
  endfunction

  // NOTE: memory arrays are never reset; only the control and output registers are.
  logic [31:0] main_mem [MAIN_DEPTH];
  logic [31:0] isp_mem  [ISP_DEPTH];

  boot_state_e state_q, state_d;
  logic [31:0] pc_q, inst_q, f_addr;
  logic        ferr_q, f_en, f_isp, f_oor;
  logic [29:0] f_idx;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    f_addr  = pc_n_i;
    f_en    = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_LOAD;
        f_addr  = RST_PC;
        f_en    = 1'b1;
      end
      S_LOAD:  state_d = S_RUN;
      S_RUN:   f_en = fetch_i;
      default: state_d = S_BOOT;
    endcase
  end

  assign f_idx = word_idx(f_addr[31:2]);
  assign f_isp = f_addr[REGION_BIT];
  assign f_oor = f_isp ? (f_idx >= ISP_LIM) : (f_idx >= MAIN_LIM);

  // NOTE: non-blocking reads here and writes below give read-first behaviour on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RST_PC;
      inst_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (f_en) begin
        pc_q   <= f_addr;
        ferr_q <= f_oor;
        if (f_oor)      inst_q <= '0;
        else if (f_isp) inst_q <= isp_mem[f_idx[ISP_AW-1:0]];
        else            inst_q <= main_mem[f_idx[MAIN_AW-1:0]];
      end
    end
  end

  assign pc_o        = pc_q;
  assign inst_o      = inst_q;
  assign fetch_err_o = ferr_q;
  assign busy_o      = (state_q != S_RUN);

  logic        w_elig, r_elig, grant_w, grant_r, prefer_w_q, prefer_w_d;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;

  always_comb begin
    w_elig     = s_awvalid & s_wvalid & (~bvalid_q | s_bready);
    r_elig     = s_arvalid & (~rvalid_q | s_rready);
    grant_w    = w_elig & (~r_elig | prefer_w_q);
    grant_r    = r_elig & ~grant_w;
    prefer_w_d = prefer_w_q;
    if (w_elig && r_elig) prefer_w_d = grant_r;
  end

  assign s_awready = grant_w;
  assign s_wready  = grant_w;
  assign s_arready = grant_r;

  logic [29:0] aw_idx, ar_idx;
  logic        aw_isp, aw_oor, aw_locked, ar_isp, ar_oor;

  assign aw_idx    = word_idx(s_awaddr[31:2]);
  assign aw_isp    = s_awaddr[REGION_BIT];
  assign aw_oor    = aw_isp ? (aw_idx >= ISP_LIM) : (aw_idx >= MAIN_LIM);
  assign aw_locked = aw_isp & isp_lock_i;
  assign ar_idx    = word_idx(s_araddr[31:2]);
  assign ar_isp    = s_araddr[REGION_BIT];
  assign ar_oor    = ar_isp ? (ar_idx >= ISP_LIM) : (ar_idx >= MAIN_LIM);

  always_ff @(posedge clk) begin
    if (grant_w && !aw_oor && !aw_locked) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) begin
          if (aw_isp) isp_mem[aw_idx[ISP_AW-1:0]][8*b +: 8]   <= s_wdata[8*b +: 8];
          else        main_mem[aw_idx[MAIN_AW-1:0]][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefer_w_q <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      prefer_w_q <= prefer_w_d;
      if (grant_w) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_oor ? RESP_DECERR : (aw_locked ? RESP_SLVERR : RESP_OKAY);
      end else if (s_bready) begin
        bvalid_q <= 1'b0;
      end
      if (grant_r) begin
        rvalid_q <= 1'b1;
        rresp_q  <= ar_oor ? RESP_DECERR : RESP_OKAY;
        if (ar_oor)      rdata_q <= '0;
        else if (ar_isp) rdata_q <= isp_mem[ar_idx[ISP_AW-1:0]];
        else             rdata_q <= main_mem[ar_idx[MAIN_AW-1:0]];
      end else if (s_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign s_bvalid = bvalid_q;
  assign s_bresp  = bresp_q;
  assign s_rvalid = rvalid_q;
  assign s_rresp  = rresp_q;
  assign s_rdata  = rdata_q;

  logic unused_bits;
  assign unused_bits = ^{s_awprot, s_arprot, s_awaddr[1:0], s_araddr[1:0]};

endmodule
